// File: rtl/gen_pkg.sv
// -----------------------------------------------------------------------------
// gen_pkg
//   Shared definitions for the gen / gen_inv pair: operating-mode encodings,
//   operand/result widths, the entry record carried through gen_inv's pipeline
//   and FIFO, and the modular arithmetic that undoes gen.
//
//   Optional build macro: GEN_INV_CHECK_EN adds a per-entry mismatch flag.
// -----------------------------------------------------------------------------
package gen_pkg;

    localparam logic OP_ADD = 1'b1;   // gen computed a + b
    localparam logic OP_SUB = 1'b0;   // gen computed a - b

    localparam int A_W   = 8;
    localparam int RES_W = 9;

    // One beat as it travels S1 -> FIFO -> output.
    typedef struct packed {
        logic [A_W-1:0] b;
        logic           ovf;
`ifdef GEN_INV_CHECK_EN
        logic           mismatch;
`endif
    } entry_t;

    // Undo gen modulo 2^RES_W. Bit A_W of the result set means the recovered
    // operand does not fit in A_W bits.
    function automatic logic [RES_W-1:0] recover_d(input logic op,
                                                    input logic [RES_W-1:0] res,
                                                    input logic [A_W-1:0] a);
        if (op == OP_ADD) begin
            return res - {1'b0, a};
        end
        return {1'b0, a} - res;
    endfunction

endpackage

// File: rtl/gen_inv_fifo.sv
// -----------------------------------------------------------------------------
// gen_inv_fifo
//   Synchronous show-ahead FIFO. dout always presents the head entry.
//   Pointers wrap modulo DEPTH (power of two); occupancy is kept in a separate
//   counter so full and empty are unambiguous. A push on a full FIFO is taken
//   only when a pop happens in the same cycle.
//
// Ports
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   push, din  write request and data
//   pop        read request (advances the head)
//   dout       head entry (storage is cleared on reset, so dout reads 0 then)
//   full       DEPTH entries held
//   empty      no entries held
// -----------------------------------------------------------------------------
module gen_inv_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gen_inv.sv
// -----------------------------------------------------------------------------
// gen_inv
//   Inverse of the gen arithmetic unit: from a gen result (res) and the operand
//   a that produced it, recover operand b. One pipeline register (S1) feeds an
//   output FIFO; together they buffer FIFO_DEPTH+1 beats.
//
// Parameters
//   OP          gen mode being inverted: OP_ADD (res=a+b) or OP_SUB (res=a-b)
//   FIFO_DEPTH  output FIFO entries, power of two, >= 2
//   CNT_W       width of the saturating event counters
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready   input handshake for res / a
//   res [8:0], a [7:0]   gen result and the operand a that produced it
//   out_valid, out_ready output handshake (out_valid = FIFO non-empty)
//   b_out [7:0], ovf     FIFO head: recovered b, and "b not representable"
//   ovf_cnt [CNT_W]      number of accepted beats with ovf=1, saturating
//
// Build option GEN_INV_CHECK_EN adds:
//   exp_b [7:0]          expected b, sampled with res / a
//   mismatch             travels with its entry: b != exp_b or ovf
//   mis_cnt [CNT_W]      number of accepted mismatching beats, saturating
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// source holds its payload stable while valid is high and ready is low;
// valid is never withdrawn by the block itself. in_ready depends
// combinationally on out_ready (S1 may drain into a FIFO slot freed by a pop
// in the same cycle).
// -----------------------------------------------------------------------------
module gen_inv
    import gen_pkg::*;
#(
    parameter logic OP         = OP_ADD,
    parameter int   FIFO_DEPTH = 4,
    parameter int   CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] res,
    input  logic [A_W-1:0]   a,
`ifdef GEN_INV_CHECK_EN
    input  logic [A_W-1:0]   exp_b,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [A_W-1:0]   b_out,
    output logic             ovf,
    output logic [CNT_W-1:0] ovf_cnt
`ifdef GEN_INV_CHECK_EN
    ,
    output logic             mismatch,
    output logic [CNT_W-1:0] mis_cnt
`endif
);

    localparam int ENTRY_W = $bits(entry_t);

    logic [RES_W-1:0]   d;
    entry_t             in_entry;
    entry_t             s1_entry;
    entry_t             head;
    logic               s1_valid;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;

    // Arithmetic on the live inputs; only the S1 copy is ever used downstream.
    assign d = recover_d(OP, res, a);

    always_comb begin
        in_entry     = '0;
        in_entry.b   = d[A_W-1:0];
        in_entry.ovf = d[A_W];
`ifdef GEN_INV_CHECK_EN
        in_entry.mismatch = (d[A_W-1:0] != exp_b) || d[A_W];
`endif
    end

    // S1 drains whenever the FIFO has a free slot, counting one freed by a
    // pop this very cycle, so a full pipeline still moves one beat per cycle.
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!fifo_full || pop);
    assign in_ready  = !s1_valid || push;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_entry <= in_entry;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (accept && in_entry.ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

`ifdef GEN_INV_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_cnt <= '0;
        end else if (accept && in_entry.mismatch && (mis_cnt != '1)) begin
            mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end
`endif

    gen_inv_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (s1_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head  = entry_t'(fifo_dout);
    assign b_out = head.b;
    assign ovf   = head.ovf;
`ifdef GEN_INV_CHECK_EN
    assign mismatch = head.mismatch;
`endif

endmodule

// File: tb/tb_gen_inv.sv
// -----------------------------------------------------------------------------
// tb_gen_inv
//   Two gen_inv instances (OP_ADD with CNT_W=16, OP_SUB with CNT_W=2) share
//   the same input stream. A negedge monitor keeps a queue of expected
//   {ovf,b} per instance computed with integer mod-512 arithmetic, and models
//   the saturating counters. Directed sections cover fixed vectors, latency,
//   capacity, full-throughput, and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_gen_inv;
    import gen_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT signals ----------------
    logic        in_valid;
    logic        out_ready;
    logic [8:0]  res;
    logic [7:0]  a;
    logic        in_ready_add, out_valid_add, ovf_add;
    logic [7:0]  b_out_add;
    logic [15:0] ovf_cnt_add;
    logic        in_ready_sub, out_valid_sub, ovf_sub;
    logic [7:0]  b_out_sub;
    logic [1:0]  ovf_cnt_sub;
`ifdef GEN_INV_CHECK_EN
    logic        corrupt;
    logic [7:0]  exp_b_add, exp_b_sub;
    logic        mismatch_add, mismatch_sub;
    logic [15:0] mis_cnt_add;
    logic [1:0]  mis_cnt_sub;
`endif

    int checks = 0;
    int errors = 0;

    // Spec-level model: recovered value modulo 512 as {ovf, b}.
    function automatic logic [8:0] inv_model(input bit is_add, input logic [8:0] r,
                                             input logic [7:0] aa);
        int v;
        if (is_add) v = int'(r) - int'(aa);
        else        v = int'(aa) - int'(r);
        v = ((v % 512) + 512) % 512;
        return 9'(v);
    endfunction

`ifdef GEN_INV_CHECK_EN
    assign exp_b_add = 8'(inv_model(1'b1, res, a)) ^ {7'b0, corrupt};
    assign exp_b_sub = 8'(inv_model(1'b0, res, a)) ^ {7'b0, corrupt};
`endif

    gen_inv #(.OP(OP_ADD), .FIFO_DEPTH(4), .CNT_W(16)) dut_add (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_add),
        .res       (res),
        .a         (a),
`ifdef GEN_INV_CHECK_EN
        .exp_b     (exp_b_add),
        .mismatch  (mismatch_add),
        .mis_cnt   (mis_cnt_add),
`endif
        .out_valid (out_valid_add),
        .out_ready (out_ready),
        .b_out     (b_out_add),
        .ovf       (ovf_add),
        .ovf_cnt   (ovf_cnt_add)
    );

    gen_inv #(.OP(OP_SUB), .FIFO_DEPTH(4), .CNT_W(2)) dut_sub (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_sub),
        .res       (res),
        .a         (a),
`ifdef GEN_INV_CHECK_EN
        .exp_b     (exp_b_sub),
        .mismatch  (mismatch_sub),
        .mis_cnt   (mis_cnt_sub),
`endif
        .out_valid (out_valid_sub),
        .out_ready (out_ready),
        .b_out     (b_out_sub),
        .ovf       (ovf_sub),
        .ovf_cnt   (ovf_cnt_sub)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q_add[$];   // {mismatch, ovf, b}
    logic [9:0] exp_q_sub[$];
    int m_ovf_add, m_ovf_sub, m_mis_add, m_mis_sub;

    always @(negedge clk) begin
        logic [8:0] da, ds;
        logic [9:0] e;
        bit         mis_a, mis_s;
        if (rst) begin
            exp_q_add.delete();
            exp_q_sub.delete();
            m_ovf_add = 0; m_ovf_sub = 0; m_mis_add = 0; m_mis_sub = 0;
        end else begin
            check("ovf_cnt_add", ovf_cnt_add, m_ovf_add);
            check("ovf_cnt_sub", ovf_cnt_sub, m_ovf_sub);
`ifdef GEN_INV_CHECK_EN
            check("mis_cnt_add", mis_cnt_add, m_mis_add);
            check("mis_cnt_sub", mis_cnt_sub, m_mis_sub);
`endif
            if (out_valid_add && out_ready) begin
                if (exp_q_add.size() == 0) check("pop_unexpected_add", 1, 0);
                else begin
                    e = exp_q_add.pop_front();
`ifdef GEN_INV_CHECK_EN
                    check("sb_add", {mismatch_add, ovf_add, b_out_add}, e);
`else
                    check("sb_add", {1'b0, ovf_add, b_out_add}, e);
`endif
                end
            end
            if (out_valid_sub && out_ready) begin
                if (exp_q_sub.size() == 0) check("pop_unexpected_sub", 1, 0);
                else begin
                    e = exp_q_sub.pop_front();
`ifdef GEN_INV_CHECK_EN
                    check("sb_sub", {mismatch_sub, ovf_sub, b_out_sub}, e);
`else
                    check("sb_sub", {1'b0, ovf_sub, b_out_sub}, e);
`endif
                end
            end
            if (in_valid && in_ready_add) begin
                da = inv_model(1'b1, res, a);
                ds = inv_model(1'b0, res, a);
                mis_a = 1'b0;
                mis_s = 1'b0;
`ifdef GEN_INV_CHECK_EN
                mis_a = corrupt || da[8];
                mis_s = corrupt || ds[8];
`endif
                exp_q_add.push_back({mis_a, da});
                exp_q_sub.push_back({mis_s, ds});
                if (da[8] && m_ovf_add < 65535) m_ovf_add++;
                if (ds[8] && m_ovf_sub < 3)     m_ovf_sub++;
                if (mis_a && m_mis_add < 65535) m_mis_add++;
                if (mis_s && m_mis_sub < 3)     m_mis_sub++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accept edge.
    task automatic send(input logic [8:0] r, input logic [7:0] aa);
        bit ok = 1'b0;
        in_valid = 1'b1;
        res      = r;
        a        = aa;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready_add;
            step();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            #1;
            done = (exp_q_add.size() == 0) && (exp_q_sub.size() == 0) && !out_valid_add;
        end
        check("drain_done", done, 1);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [8:0] beat_res(input int i);
        return 9'(i * 37 + 5);
    endfunction
    function automatic logic [7:0] beat_a(input int i);
        return 8'(i * 11);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [8:0] res;
        logic [7:0] a;
        logic [8:0] add_d;   // {ovf, b} for OP_ADD
        logic [8:0] sub_d;   // {ovf, b} for OP_SUB
    } vec_t;
    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, stalls, n;
        bit took;

        vecs[0] = '{9'd5,    8'd3,    9'h002, 9'h1FE};
        vecs[1] = '{9'd14,   8'd10,   9'h004, 9'h1FC};
        vecs[2] = '{9'd1,    8'd3,    9'h1FE, 9'h002};
        vecs[3] = '{9'h1FA,  8'd10,   9'h1F0, 9'h010};
        vecs[4] = '{9'd2,    8'd3,    9'h1FF, 9'h001};
        vecs[5] = '{9'h1FF,  8'hFF,   9'h100, 9'h100};
        vecs[6] = '{9'd0,    8'd0,    9'h000, 9'h000};
        vecs[7] = '{9'h100,  8'd0,    9'h100, 9'h100};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; res = '0; a = '0;
`ifdef GEN_INV_CHECK_EN
        corrupt = 1'b0;
`endif
        #1;
        check("rst_out_valid", out_valid_add, 0);
        check("rst_b_out", b_out_add, 0);
        check("rst_ovf", ovf_add, 0);
        check("rst_ovf_cnt", ovf_cnt_add, 0);
        check("rst_in_ready", in_ready_add, 1);
        step();
        step();
        rst = 1'b0;
        step();

        // Fixed vectors, one at a time; also checks the two-edge latency.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].res, vecs[i].a);
            @(negedge clk);
            check("lat_not_yet", out_valid_add, 0);
            @(negedge clk);
            check("lat_visible", out_valid_add, 1);
            check($sformatf("vec%0d_add", i), {ovf_add, b_out_add}, vecs[i].add_d);
            check($sformatf("vec%0d_sub", i), {ovf_sub, b_out_sub}, vecs[i].sub_d);
            step();
        end
        drain();

        // Overflow counting from a clean reset.
        do_reset();
        send(9'd2, 8'd3);
        check("ovf_cnt_first", ovf_cnt_add, 1);
        send(9'd2, 8'd3);
        send(9'd2, 8'd3);
        drain();
        check("ovf_cnt_three", ovf_cnt_add, 3);
        check("ovf_cnt_sub_none", ovf_cnt_sub, 0);

        // Capacity: 7 offered with out_ready=0, exactly 5 taken.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 7);
            res = beat_res(idx);
            a   = beat_a(idx);
            @(negedge clk);
            took = in_valid && in_ready_add;
            step();
            if (took) idx++;
        end
        check("cap_accepted", idx, 5);
        check("cap_in_ready_low", in_ready_add, 0);
        check("cap_out_valid", out_valid_add, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_with_first_pop", in_ready_add, 1);
        step();
        in_valid = 1'b0;
        send(beat_res(6), beat_a(6));
        drain();

        // Full pipeline with continuous traffic: no stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        res = 9'($urandom); a = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            took = in_ready_add;
            step();
            if (took) begin res = 9'($urandom); a = 8'($urandom); end
        end
        check("full_before_stream", in_ready_add, 0);
        out_ready = 1'b1;
        stalls = 0; n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            took = in_ready_add;
            if (took) n++; else stalls++;
            step();
            if (took) begin res = 9'($urandom); a = 8'($urandom); end
        end
        in_valid = 1'b0;
        check("stream_stalls", stalls, 0);
        check("stream_beats", n, 20);
        drain();

        // Reset with beats in flight.
        out_ready = 1'b0;
        send(9'd2, 8'd3);
        send(9'd2, 8'd3);
        send(9'd2, 8'd3);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid_add, 0);
        check("midrst_ovf_cnt", ovf_cnt_add, 0);
        check("midrst_out_valid_sub", out_valid_sub, 0);
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        send(9'd14, 8'd10);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_valid", out_valid_add, 1);
        check("post_rst_b", {ovf_add, b_out_add}, 9'h004);
        step();
        drain();

        // gen(a=i+10, b=i+3) stream, back to back.
        for (int i = 1; i <= 99; i++) begin
            send(9'((i + 10) + (i + 3)), 8'(i + 10));
        end
        drain();

        // Random traffic with random backpressure.
        n = 0; took = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 3000 && n < 200; c++) begin
            if (!in_valid || took) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1; res = 9'($urandom); a = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready_add;
            if (took) n++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("random_beats", n, 200);
        drain();

`ifdef GEN_INV_CHECK_EN
        do_reset();
        for (int i = 1; i <= 20; i++) send(9'((i + 10) + (i + 3)), 8'(i + 10));
        drain();
        check("mis_cnt_clean", mis_cnt_add, 0);
        corrupt = 1'b1;
        send(9'd14, 8'd10);
        corrupt = 1'b0;
        drain();
        check("mis_cnt_one", mis_cnt_add, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
